// File: rtl/wb_line_pkg.sv
// Shared FSM encoding and beat-geometry constants for wb_line_splitter.
package wb_line_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BEAT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int DEF_LINE_WIDTH = 128;
   localparam int DEF_MEM_WIDTH  = 32;
   localparam int DEF_GRAN       = 8;

   localparam int BEATS     = DEF_LINE_WIDTH / DEF_MEM_WIDTH;
   localparam int MEM_BYTES = DEF_MEM_WIDTH / DEF_GRAN;

   function automatic int calc_beats(input int line_w, input int mem_w);
      return line_w / mem_w;
   endfunction

   function automatic int calc_mem_bytes(input int mem_w, input int gran);
      return mem_w / gran;
   endfunction

endpackage

// File: rtl/wb_line_splitter_beat_find.sv
// Priority search: lowest beat index >= cur_i whose byte-enable slice is nonzero.
module beat_find #(
   parameter int BEATS_N     = 4,
   parameter int MEM_BYTES_N = 4,
   parameter int IDX_W       = 2
) (
   input  logic [BEATS_N*MEM_BYTES_N-1:0] sel_i,
   input  logic [IDX_W:0]                 cur_i,
   output logic [IDX_W-1:0]               next_o,
   output logic                           none_o
);

   logic [BEATS_N-1:0] cand;

   generate
      for (genvar gi = 0; gi < BEATS_N; gi++) begin : g_cand
         assign cand[gi] = (|sel_i[gi*MEM_BYTES_N +: MEM_BYTES_N]) &&
                           ((IDX_W+1)'(gi) >= cur_i);
      end
   endgenerate

   always_comb begin
      next_o = '0;
      for (int i = BEATS_N - 1; i >= 0; i--) begin
         if (cand[i]) next_o = i[IDX_W-1:0];
      end
   end

   assign none_o = ~|cand;

endmodule

// File: rtl/wb_line_splitter.sv
// Splits one Wishbone line access into ascending MEM_WIDTH beats, skipping unselected beats.
// Optional beat timeout with wb_err_o is enabled by defining WB_LINE_SPLITTER_TIMEOUT_EN.
module wb_line_splitter
   import wb_line_pkg::*;
#(
   parameter int LINE_WIDTH       = DEF_LINE_WIDTH,
   parameter int ADDR_WIDTH       = 32,
   parameter int MEM_WIDTH        = DEF_MEM_WIDTH,
   parameter int ADDR_GRANULARITY = DEF_GRAN,
   parameter int TIMEOUT_CYCLES   = 255
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [ADDR_WIDTH-1:0]                  wb_adr_i,
   input  logic [LINE_WIDTH-1:0]                  wb_dat_i,
   output logic [LINE_WIDTH-1:0]                  wb_dat_o,
   input  logic                                   wb_we_i,
   input  logic                                   wb_stb_i,
   input  logic                                   wb_cyc_i,
   input  logic [LINE_WIDTH/ADDR_GRANULARITY-1:0] wb_sel_i,
   output logic                                   wb_ack_o,
   output logic                                   wb_err_o,
   output logic                                   wb_rty_o,
   output logic [ADDR_WIDTH-1:0]                  mem_adr_o,
   output logic [MEM_WIDTH-1:0]                   mem_dat_o,
   input  logic [MEM_WIDTH-1:0]                   mem_dat_i,
   output logic [MEM_WIDTH/ADDR_GRANULARITY-1:0]  mem_sel_o,
   output logic                                   mem_we_o,
   output logic                                   mem_req_o,
   input  logic                                   mem_ack_i
);

   localparam int BEATS_P  = calc_beats(LINE_WIDTH, MEM_WIDTH);
   localparam int MB_P     = calc_mem_bytes(MEM_WIDTH, ADDR_GRANULARITY);
   localparam int SEL_W    = LINE_WIDTH / ADDR_GRANULARITY;
   localparam int IW       = $clog2(BEATS_P);
   localparam int MB_SHIFT = $clog2(MB_P);

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         beat_q, beat_d;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [LINE_WIDTH-1:0] dat_q;
   logic [SEL_W-1:0]      sel_q;
   logic                  we_q;
   logic [MEM_WIDTH-1:0]  buf_q [BEATS_P];

   logic [MB_P-1:0]       sel_slc [BEATS_P];
   logic [MEM_WIDTH-1:0]  dat_slc [BEATS_P];
   logic [LINE_WIDTH-1:0] buf_line;
   logic [MB_P-1:0]       cur_sel;
   logic [MEM_WIDTH-1:0]  rd_mask;

   logic                  in_beat, beat_ack, accept, tmo_hit;
   logic [SEL_W-1:0]      find_sel;
   logic [IW:0]           find_from;
   logic [IW-1:0]         find_idx;
   logic                  find_none;

   generate
      for (genvar gi = 0; gi < BEATS_P; gi++) begin : g_slice
         assign sel_slc[gi] = sel_q[gi*MB_P +: MB_P];
         assign dat_slc[gi] = dat_q[gi*MEM_WIDTH +: MEM_WIDTH];
         assign buf_line[gi*MEM_WIDTH +: MEM_WIDTH] = buf_q[gi];
      end
      for (genvar gi = 0; gi < MB_P; gi++) begin : g_mask
         assign rd_mask[gi*ADDR_GRANULARITY +: ADDR_GRANULARITY] = {ADDR_GRANULARITY{cur_sel[gi]}};
      end
   endgenerate

   assign cur_sel  = sel_slc[beat_q];
   assign in_beat  = (state_q == ST_BEAT);
   assign beat_ack = in_beat && mem_ack_i;
   assign accept   = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;

   // In IDLE the search runs on the live byte enables from beat 0; in BEAT it
   // looks past the current beat in the latched enables.
   assign find_sel  = (state_q == ST_IDLE) ? wb_sel_i : sel_q;
   assign find_from = (state_q == ST_IDLE) ? '0 : ((IW+1)'(beat_q) + (IW+1)'(1));

   beat_find #(
      .BEATS_N     (BEATS_P),
      .MEM_BYTES_N (MB_P),
      .IDX_W       (IW)
   ) u_beat_find (
      .sel_i  (find_sel),
      .cur_i  (find_from),
      .next_o (find_idx),
      .none_o (find_none)
   );

`ifdef WB_LINE_SPLITTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q;

   assign tmo_hit = in_beat && !mem_ack_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      tmo_d = tmo_q + TW'(1);
      if (!in_beat || mem_ack_i || tmo_hit) tmo_d = '0;
   end

   // err_q marks a DONE cycle that was entered through a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= tmo_hit;
      end
   end

   assign wb_err_o = (state_q == ST_DONE) && err_q;
`else
   assign tmo_hit  = 1'b0;
   assign wb_err_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (find_none) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BEAT;
                  beat_d  = find_idx;
               end
            end
         end
         ST_BEAT: begin
            if (beat_ack) begin
               if (!wb_cyc_i)      state_d = ST_IDLE;
               else if (find_none) state_d = ST_DONE;
               else                beat_d  = find_idx;
            end else if (tmo_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         for (int i = 0; i < BEATS_P; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (accept) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
            for (int i = 0; i < BEATS_P; i++) buf_q[i] <= '0;
         end else if (beat_ack && !we_q) begin
            buf_q[beat_q] <= mem_dat_i & rd_mask;
         end
      end
   end

   assign wb_ack_o  = (state_q == ST_DONE) && !wb_err_o;
   assign wb_dat_o  = (wb_ack_o && !we_q) ? buf_line : '0;
   assign wb_rty_o  = 1'b0;

   assign mem_req_o = in_beat;
   assign mem_we_o  = in_beat && we_q;
   assign mem_adr_o = in_beat ? (adr_q + (ADDR_WIDTH'(beat_q) << MB_SHIFT)) : '0;
   assign mem_sel_o = in_beat ? cur_sel : '0;
   assign mem_dat_o = in_beat ? dat_slc[beat_q] : '0;

endmodule

// File: tb/tb_wb_line_splitter.sv
// Directed bench for wb_line_splitter; timeout case built only with WB_LINE_SPLITTER_TIMEOUT_EN.
module tb_wb_line_splitter;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   wb_adr;
   logic [127:0]  wb_dat, wb_dat_o;
   logic          wb_we, wb_stb, wb_cyc;
   logic [15:0]   wb_sel;
   logic          wb_ack, wb_err, wb_rty;
   logic [31:0]   mem_adr, mem_dat_o, mem_dat_i;
   logic [3:0]    mem_sel;
   logic          mem_we, mem_req, mem_ack;

   int            wait_n = 0;
   int            wcnt;
   int            n_vec = 0;
   int            n_err = 0;

   logic [31:0]   log_adr [16];
   logic [3:0]    log_sel [16];
   logic [31:0]   log_dat [16];
   logic          log_we  [16];
   int            log_n;
   int            ack_cyc, err_cyc;
   logic [127:0]  ack_dat;

   always #5 clk = ~clk;

   wb_line_splitter #(.TIMEOUT_CYCLES(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb_adr_i  (wb_adr),
      .wb_dat_i  (wb_dat),
      .wb_dat_o  (wb_dat_o),
      .wb_we_i   (wb_we),
      .wb_stb_i  (wb_stb),
      .wb_cyc_i  (wb_cyc),
      .wb_sel_i  (wb_sel),
      .wb_ack_o  (wb_ack),
      .wb_err_o  (wb_err),
      .wb_rty_o  (wb_rty),
      .mem_adr_o (mem_adr),
      .mem_dat_o (mem_dat_o),
      .mem_dat_i (mem_dat_i),
      .mem_sel_o (mem_sel),
      .mem_we_o  (mem_we),
      .mem_req_o (mem_req),
      .mem_ack_i (mem_ack)
   );

   // Memory: acks after wait_n wait states, read data tagged with the beat address.
   assign mem_ack   = mem_req && (wcnt == wait_n);
   assign mem_dat_i = 32'hC0DE_0000 | {16'h0, mem_adr[15:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   wcnt <= 0;
      else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
      else                       wcnt <= 0;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run_txn(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                          input logic [127:0] dat);
      log_n   = 0;
      ack_cyc = -1;
      err_cyc = -1;
      ack_dat = '0;
      @(posedge clk);
      #1;
      wb_adr = adr; wb_we = we; wb_sel = sel; wb_dat = dat;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 64; c++) begin
         @(negedge clk);
         if (mem_req && mem_ack && log_n < 16) begin
            log_adr[log_n] = mem_adr;
            log_sel[log_n] = mem_sel;
            log_dat[log_n] = mem_dat_o;
            log_we[log_n]  = mem_we;
            log_n++;
         end
         if (wb_ack || wb_err) begin
            if (wb_ack) begin
               ack_cyc = c;
               ack_dat = wb_dat_o;
            end else begin
               err_cyc = c;
            end
            wb_cyc = 1'b0; wb_stb = 1'b0;
            break;
         end
      end
      wb_cyc = 1'b0; wb_stb = 1'b0;
      $display("txn adr=%h we=%0d sel=%h beats=%0d ack_cyc=%0d err_cyc=%0d dat=%h",
               adr, we, sel, log_n, ack_cyc, err_cyc, ack_dat);
   endtask

   initial begin
      logic found;
      int   acks;
      rst = 1'b1;
      wb_adr = '0; wb_dat = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0; wb_sel = '0;
      #2;
      chk("rst_ack", wb_ack, 1'b0);
      chk("rst_err", wb_err, 1'b0);
      chk("rst_rty", wb_rty, 1'b0);
      chk("rst_wb_dat", wb_dat_o, '0);
      chk("rst_mem", {mem_req, mem_we, mem_sel, mem_adr, mem_dat_o}, '0);
      #10;
      rst = 1'b0;

      // Full-line read, zero-wait memory.
      wait_n = 0;
      run_txn(32'h0000_1000, 1'b0, 16'hFFFF, '0);
      chk("t1_beats", 128'(log_n), 128'd4);
      chk("t1_adr0", log_adr[0], 32'h0000_1000);
      chk("t1_adr1", log_adr[1], 32'h0000_1004);
      chk("t1_adr2", log_adr[2], 32'h0000_1008);
      chk("t1_adr3", log_adr[3], 32'h0000_100C);
      chk("t1_ack_cyc", 128'(ack_cyc), 128'd5);
      chk("t1_dat", ack_dat, 128'hC0DE100C_C0DE1008_C0DE1004_C0DE1000);
      chk("t1_no_err", err_cyc < 0, 1'b1);

      // Single-beat write of word 1.
      run_txn(32'h0000_2000, 1'b1, 16'h00F0,
              128'h11111111_22222222_DEADBEEF_33333333);
      chk("t2_beats", 128'(log_n), 128'd1);
      chk("t2_adr", log_adr[0], 32'h0000_2004);
      chk("t2_sel", log_sel[0], 4'hF);
      chk("t2_mdat", log_dat[0], 32'hDEADBEEF);
      chk("t2_we", log_we[0], 1'b1);
      chk("t2_ack_cyc", 128'(ack_cyc), 128'd2);
      chk("t2_dat", ack_dat, '0);

      // Nothing selected: immediate ack, no memory traffic.
      run_txn(32'h0000_2000, 1'b0, 16'h0000, '0);
      chk("t3_beats", 128'(log_n), 128'd0);
      chk("t3_ack_cyc", 128'(ack_cyc), 128'd1);
      chk("t3_dat", ack_dat, '0);

      // Sparse read, 3 wait states per beat.
      wait_n = 3;
      run_txn(32'h0000_3000, 1'b0, 16'hF00F, '0);
      chk("t4_beats", 128'(log_n), 128'd2);
      chk("t4_adr0", log_adr[0], 32'h0000_3000);
      chk("t4_adr1", log_adr[1], 32'h0000_300C);
      chk("t4_ack_cyc", 128'(ack_cyc), 128'd9);
      chk("t4_dat", ack_dat, 128'hC0DE300C_00000000_00000000_C0DE3000);

      // Partial slice: unselected bytes of a read beat come back as zero.
      wait_n = 0;
      run_txn(32'h0000_4000, 1'b0, 16'h0030, '0);
      chk("t5_beats", 128'(log_n), 128'd1);
      chk("t5_sel", log_sel[0], 4'h3);
      chk("t5_ack_cyc", 128'(ack_cyc), 128'd2);
      chk("t5_dat", ack_dat, 128'h00000000_00000000_00004004_00000000);

      // Cycle dropped mid-beat: beat finishes, no ack follows.
      wait_n = 2;
      log_n  = 0;
      acks   = 0;
      @(posedge clk);
      #1;
      wb_adr = 32'h0000_7000; wb_we = 1'b0; wb_sel = 16'hFFFF;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t6_req", mem_req, 1'b1);
      wb_cyc = 1'b0; wb_stb = 1'b0;
      for (int c = 2; c <= 10; c++) begin
         @(negedge clk);
         if (mem_req && mem_ack) begin
            log_adr[0] = mem_adr;
            log_n++;
         end
         if (wb_ack) acks++;
      end
      $display("txn adr=00007000 cyc_drop beats=%0d acks=%0d", log_n, acks);
      chk("t6_beats", 128'(log_n), 128'd1);
      chk("t6_adr", log_adr[0], 32'h0000_7000);
      chk("t6_acks", 128'(acks), 128'd0);
      chk("t6_idle", mem_req, 1'b0);

      // Asynchronous reset in beat 2, then a clean full read.
      wait_n = 3;
      found  = 1'b0;
      @(posedge clk);
      #1;
      wb_adr = 32'h0000_5000; wb_we = 1'b0; wb_sel = 16'hFFFF;
      wb_cyc = 1'b1; wb_stb = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (mem_req && mem_adr == 32'h0000_5008) begin
            found = 1'b1;
            break;
         end
      end
      chk("t7_beat2_seen", found, 1'b1);
      #1;
      rst = 1'b1;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      #1;
      chk("t7_rst_mem", {mem_req, mem_we, mem_sel, mem_adr, mem_dat_o}, '0);
      chk("t7_rst_wb", {wb_ack, wb_err, wb_dat_o}, '0);
      #1;
      rst = 1'b0;
      $display("txn adr=00005000 reset_in_beat2 found=%0d", found);

      wait_n = 0;
      run_txn(32'h0000_6000, 1'b0, 16'hFFFF, '0);
      chk("t8_beats", 128'(log_n), 128'd4);
      chk("t8_ack_cyc", 128'(ack_cyc), 128'd5);
      chk("t8_dat", ack_dat, 128'hC0DE600C_C0DE6008_C0DE6004_C0DE6000);

`ifdef WB_LINE_SPLITTER_TIMEOUT_EN
      // Memory never acks: error after 8 beat cycles, no ack.
      wait_n = 1000;
      run_txn(32'h0000_8000, 1'b0, 16'h000F, '0);
      chk("t9_err_cyc", 128'(err_cyc), 128'd9);
      chk("t9_no_ack", ack_cyc < 0, 1'b1);
      @(negedge clk);
      chk("t9_idle", {mem_req, wb_err, wb_ack}, '0);
      wait_n = 0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/wb_line_splitter.md
WB_LINE_SPLITTER -- requirements
Module: wb_line_splitter

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 128, meaning the Wishbone line data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 SHALL have parameter MEM_WIDTH, default 32, meaning the external memory data width; LINE_WIDTH/MEM_WIDTH (BEATS) SHALL be a power of two of at least 2.
REQ-004 SHALL have parameter ADDR_GRANULARITY, default 8, meaning the bits per address unit (byte).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum wait for mem_ack_i (used only under REQ-027).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 wb_adr_i  in  ADDR_WIDTH  line-aligned byte address.
REQ-009 wb_dat_i / wb_dat_o  in/out  LINE_WIDTH  write line / assembled read line.
REQ-010 wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  Wishbone classic slave controls.
REQ-011 wb_sel_i  in  LINE_WIDTH/ADDR_GRANULARITY  byte enables.
REQ-012 wb_ack_o, wb_err_o, wb_rty_o  out  1 each  termination; wb_rty_o is constant 0.
REQ-013 mem_adr_o  out  ADDR_WIDTH  beat byte address; mem_dat_o out / mem_dat_i in, MEM_WIDTH each; mem_sel_o  out  MEM_WIDTH/ADDR_GRANULARITY; mem_we_o, mem_req_o  out  1; mem_ack_i  in  1.

Function
REQ-014 SHALL implement FSM states IDLE, BEAT, DONE.
REQ-015 IDLE: on wb_cyc_i & wb_stb_i, the block SHALL latch address, write data, we and sel, clear the read buffer to 0, and go to BEAT at the first beat whose sel slice is nonzero, or to DONE if all of sel is zero.
REQ-016 BEAT k: mem_req_o=1, mem_adr_o = line base + k*MEM_WIDTH/ADDR_GRANULARITY, mem_sel_o/mem_dat_o = slice k, mem_we_o = latched we.
REQ-017 Beats with an all-zero sel slice SHALL be skipped; beats SHALL be issued in ascending order.
REQ-018 On mem_req_o & mem_ack_i, a read SHALL store mem_dat_i into buffer slice k with unselected bytes forced to 0; the FSM SHALL then advance to the next selected beat the following cycle, or to DONE if none remains.
REQ-019 DONE: wb_ack_o=1 for exactly one cycle, with wb_dat_o = buffer (reads) and 0 (writes); then IDLE.
REQ-020 Latency: with N selected beats and zero-wait memory, wb_ack_o SHALL be high in the cycle N+1 after the accepting edge.
REQ-021 mem_ack_i without mem_req_o SHALL be ignored.
REQ-022 If wb_cyc_i drops during BEAT, the current beat SHALL complete, then the FSM SHALL return to IDLE with no wb_ack_o.
REQ-023 wb_stb_i in DONE or on the cycle of wb_ack_o SHALL NOT start a new transaction.

Reset
REQ-024 rst SHALL force IDLE immediately, regardless of the clock.
REQ-025 Reset values SHALL be: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, mem_req_o=0, mem_we_o=0, mem_sel_o=0, mem_adr_o=0, mem_dat_o=0, buffer=0, timeout counter=0.
REQ-026 A reset asserted mid-beat SHALL abandon the beat; the next transaction SHALL start cleanly.

Configuration
REQ-027 With WB_LINE_SPLITTER_TIMEOUT_EN defined, a counter SHALL run in BEAT and reset on each beat change; on reaching TIMEOUT_CYCLES it SHALL drop mem_req_o, pulse wb_err_o (not wb_ack_o) for one cycle, and return to IDLE.
REQ-028 Without WB_LINE_SPLITTER_TIMEOUT_EN, wb_err_o SHALL be constant 0, no counter SHALL exist, and BEAT SHALL wait indefinitely.

Structure
REQ-029 The FSM state encoding and the BEATS and MEM_BYTES constants SHALL live in shared package wb_line_pkg.
REQ-030 The next-selected-beat priority search SHALL be a sub-module, beat_find (inputs: sel, current index; outputs: next index, none-left flag).

Verification
REQ-031 Read, sel=16'hFFFF, adr=32'h0000_1000, zero-wait memory -> beats at 0x1000/0x1004/0x1008/0x100C; wb_ack_o in cycle 5; wb_dat_o equals the 4 returned words, beat0 in bits [31:0].
REQ-032 Write, sel=16'h00F0, datain word1=32'hDEADBEEF -> exactly one beat at adr+4, mem_sel_o=4'hF, mem_dat_o=32'hDEADBEEF; wb_ack_o in cycle 2.
REQ-033 Read, sel=16'h0000 -> no mem_req_o; wb_ack_o in cycle 1 with wb_dat_o=0.
REQ-034 Read, sel=16'hF00F, memory with 3 wait states per beat -> beats 0 and 3 only; the bytes of beats 1 and 2 read back as 0.
REQ-035 rst pulsed while mem_req_o=1 in beat 2 -> all outputs 0 without a clock edge; a subsequent full-line read completes normally.
REQ-036 With WB_LINE_SPLITTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks -> wb_err_o pulses once 8 cycles into the beat; wb_ack_o stays 0; the FSM returns to IDLE.
